// File: rtl/scalar_idx_bank.sv
`default_nettype none
// ============================================================================
// Module   : scalar_idx_bank
// Purpose  : Bank of NUM_CNT loop-index counters for the vector decode stage.
//            Each counter has its own limit. Supported operations are single
//            increment, chained increment with carry into higher counters,
//            limit/counter load, clear, clear-all, and a registered snapshot
//            read.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            op_valid_i        - op/sel/imm qualify this cycle
//            op_i [2:0]        - operation code
//            sel_i [SEL_W]     - target counter
//            imm_i [DATA_W]    - immediate for SETLIM / SETCNT
//            cnt_out_o, lim_out_o - packed snapshot, counter k at [k*DATA_W +: DATA_W]
//            rd_valid_o        - snapshot updated (1-cycle pulse)
//            wrap_o [NUM_CNT]  - per-counter wrap pulse
//            ovf_o             - chained carry left the top counter
//            err_o             - select out of range, op ignored
// Options  : SCA_IDX_SAT_EN    - when defined, INCR saturates at the limit
//                                instead of wrapping (INCR_CHAIN unchanged)
// Revision : 1.0 - initial release
// ============================================================================
module scalar_idx_bank #(
  parameter int DATA_W  = 32,
  parameter int NUM_CNT = 4,
  parameter int SEL_W   = $clog2(NUM_CNT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        op_valid_i,
  input  logic [2:0]                  op_i,
  input  logic [SEL_W-1:0]            sel_i,
  input  logic [DATA_W-1:0]           imm_i,
  output logic [NUM_CNT*DATA_W-1:0]   cnt_out_o,
  output logic [NUM_CNT*DATA_W-1:0]   lim_out_o,
  output logic                        rd_valid_o,
  output logic [NUM_CNT-1:0]          wrap_o,
  output logic                        ovf_o,
  output logic                        err_o
);

  localparam logic [2:0] c_OP_NOP    = 3'b000;
  localparam logic [2:0] c_OP_INCR   = 3'b001;
  localparam logic [2:0] c_OP_CHAIN  = 3'b010;
  localparam logic [2:0] c_OP_SETLIM = 3'b011;
  localparam logic [2:0] c_OP_SETCNT = 3'b100;
  localparam logic [2:0] c_OP_CLR    = 3'b101;
  localparam logic [2:0] c_OP_READ   = 3'b110;
  localparam logic [2:0] c_OP_CLRALL = 3'b111;

  // One extra bit so NUM_CNT itself is representable when it is a power of 2.
  localparam logic [SEL_W:0] c_NUM_CNT = (SEL_W+1)'(NUM_CNT);
  localparam logic [DATA_W-1:0] c_ONE  = DATA_W'(1);

  logic [DATA_W-1:0]         cnt_q [NUM_CNT];
  logic [DATA_W-1:0]         cnt_d [NUM_CNT];
  logic [DATA_W-1:0]         lim_q [NUM_CNT];
  logic [DATA_W-1:0]         lim_d [NUM_CNT];
  logic [NUM_CNT*DATA_W-1:0] cnt_out_q, cnt_out_d;
  logic [NUM_CNT*DATA_W-1:0] lim_out_q, lim_out_d;
  logic                      rd_valid_q, rd_valid_d;
  logic [NUM_CNT-1:0]        wrap_q, wrap_d;
  logic                      ovf_q, ovf_d;
  logic                      err_q, err_d;

  logic                      w_sel_ok;
  logic                      w_sel_op;
  logic                      carry;

  assign w_sel_ok = ({1'b0, sel_i} < c_NUM_CNT);
  // Ops that address a single counter and therefore care about sel.
  assign w_sel_op = (op_i >= c_OP_INCR) && (op_i <= c_OP_CLR);

  always_comb begin
    for (int k = 0; k < NUM_CNT; k++) begin
      cnt_d[k] = cnt_q[k];
      lim_d[k] = lim_q[k];
    end
    cnt_out_d  = cnt_out_q;
    lim_out_d  = lim_out_q;
    rd_valid_d = 1'b0;
    wrap_d     = '0;
    ovf_d      = 1'b0;
    err_d      = 1'b0;
    carry      = 1'b0;

    if (op_valid_i) begin
      if (w_sel_op && !w_sel_ok) begin
        err_d = 1'b1;
      end else begin
        case (op_i)
          c_OP_INCR: begin
            for (int k = 0; k < NUM_CNT; k++) begin
              if (sel_i == SEL_W'(k)) begin
                if (cnt_q[k] >= lim_q[k]) begin
`ifdef SCA_IDX_SAT_EN
                  cnt_d[k] = lim_q[k];
`else
                  cnt_d[k] = '0;
`endif
                  wrap_d[k] = 1'b1;
                end else begin
                  cnt_d[k] = cnt_q[k] + c_ONE;
`ifdef SCA_IDX_SAT_EN
                  // Flag the edge on which the counter first reaches its limit.
                  wrap_d[k] = ((cnt_q[k] + c_ONE) == lim_q[k]);
`endif
                end
              end
            end
          end
          c_OP_CHAIN: begin
            // Ascending walk: the selected counter increments, and every
            // wrapping counter passes a carry to the next one up.
            for (int k = 0; k < NUM_CNT; k++) begin
              if ((sel_i == SEL_W'(k)) || carry) begin
                if (cnt_q[k] >= lim_q[k]) begin
                  cnt_d[k]  = '0;
                  wrap_d[k] = 1'b1;
                  carry     = 1'b1;
                end else begin
                  cnt_d[k]  = cnt_q[k] + c_ONE;
                  carry     = 1'b0;
                end
              end
            end
            ovf_d = carry;
          end
          c_OP_SETLIM: begin
            for (int k = 0; k < NUM_CNT; k++)
              if (sel_i == SEL_W'(k)) lim_d[k] = imm_i;
          end
          c_OP_SETCNT: begin
            for (int k = 0; k < NUM_CNT; k++)
              if (sel_i == SEL_W'(k))
                cnt_d[k] = (imm_i < lim_q[k]) ? imm_i : lim_q[k];
          end
          c_OP_CLR: begin
            for (int k = 0; k < NUM_CNT; k++)
              if (sel_i == SEL_W'(k)) cnt_d[k] = '0;
          end
          c_OP_READ: begin
            for (int k = 0; k < NUM_CNT; k++) begin
              cnt_out_d[k*DATA_W +: DATA_W] = cnt_q[k];
              lim_out_d[k*DATA_W +: DATA_W] = lim_q[k];
            end
            rd_valid_d = 1'b1;
          end
          c_OP_CLRALL: begin
            for (int k = 0; k < NUM_CNT; k++) cnt_d[k] = '0;
          end
          c_OP_NOP: ;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_q[k] <= '0;
        lim_q[k] <= '0;
      end
      cnt_out_q  <= '0;
      lim_out_q  <= '0;
      rd_valid_q <= 1'b0;
      wrap_q     <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_q[k] <= cnt_d[k];
        lim_q[k] <= lim_d[k];
      end
      cnt_out_q  <= cnt_out_d;
      lim_out_q  <= lim_out_d;
      rd_valid_q <= rd_valid_d;
      wrap_q     <= wrap_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign cnt_out_o  = cnt_out_q;
  assign lim_out_o  = lim_out_q;
  assign rd_valid_o = rd_valid_q;
  assign wrap_o     = wrap_q;
  assign ovf_o      = ovf_q;
  assign err_o      = err_q;

endmodule
`default_nettype wire
